// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared FSM state type and tag-width helper for the stream sink arbiter
package stream_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACK, SEND} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stream_rr_pick.sv
// stream_rr_pick: combinational rotate-priority picker, first requester at or above ptr wins
module stream_rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W = clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);
  // scan from the farthest offset down so the nearest requester (mod N_PORTS) overwrites last
  always_comb begin
    valid = |req;
    idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_PORTS]) idx = IDX_W'((int'(ptr) + k) % N_PORTS);
  end
endmodule

// File: rtl/stream_sink_arbiter.sv
// stream_sink_arbiter: round-robin share of one stb/ack sink among N_PORTS producers, tagging each sample
module stream_sink_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W = 32,
  parameter int BURST = 1,
  parameter int IDX_W = clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_stb,
  output logic [N_PORTS-1:0]        in_ack,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_tag,
  output logic                      out_stb,
  input  logic                      out_ack,
  output logic [N_PORTS-1:0]        grant,
  output logic [31:0]               xfer_count
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, gidx, gidx_nxt, tag_nxt, pick_idx;
  logic [31:0] burst_cnt, burst_nxt, xfer_nxt;
  logic [N_PORTS-1:0] ack_nxt, grant_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic stb_nxt, pick_valid;
  stream_rr_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_pick (
    .req(in_stb), .ptr(ptr), .valid(pick_valid), .idx(pick_idx)
  );
  // next-state and datapath: every register keeps its value unless the current state updates it
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    gidx_nxt = gidx;
    burst_nxt = burst_cnt;
    ack_nxt = in_ack;
    grant_nxt = grant;
    data_nxt = out_data;
    tag_nxt = out_tag;
    stb_nxt = out_stb;
    xfer_nxt = xfer_count;
    case (state)
      IDLE: if (pick_valid) begin
        gidx_nxt = pick_idx;
        grant_nxt = N_PORTS'(1) << pick_idx;
        ack_nxt = N_PORTS'(1) << pick_idx;
        burst_nxt = '0;
        state_nxt = ACK;
      end
      ACK: begin
        ack_nxt = '0;
        if (in_stb[gidx]) begin
          data_nxt = in_data[int'(gidx)*DATA_W +: DATA_W];
          tag_nxt = gidx;
          stb_nxt = 1'b1;
          state_nxt = SEND;
        end else begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      SEND: if (out_ack) begin
        stb_nxt = 1'b0;
        xfer_nxt = xfer_count + 32'd1;
        if (burst_cnt + 32'd1 < 32'(BURST) && in_stb[gidx]) begin
          burst_nxt = burst_cnt + 32'd1;
          ack_nxt = N_PORTS'(1) << gidx;
          state_nxt = ACK;
        end else begin
          ptr_nxt = (int'(gidx) == N_PORTS - 1) ? '0 : gidx + 1'b1;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  // register all state; synchronous active-low reset drops any held sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      burst_cnt <= '0;
      in_ack <= '0;
      grant <= '0;
      out_data <= '0;
      out_tag <= '0;
      out_stb <= 1'b0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      gidx <= gidx_nxt;
      burst_cnt <= burst_nxt;
      in_ack <= ack_nxt;
      grant <= grant_nxt;
      out_data <= data_nxt;
      out_tag <= tag_nxt;
      out_stb <= stb_nxt;
      xfer_count <= xfer_nxt;
    end
  end
endmodule

// File: tb/tb_stream_sink_arbiter.sv
// tb_stream_sink_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_stream_sink_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, out_ack, out_stb;
  logic [N-1:0] in_stb, in_ack, grant;
  logic [N*W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [1:0] out_tag;
  logic [31:0] xfer_count;
  logic b_rst_n, b_out_stb;
  logic [N-1:0] b_in_stb, b_in_ack, b_grant;
  logic [N*W-1:0] b_in_data;
  logic [W-1:0] b_out_data;
  logic [1:0] b_out_tag;
  logic [31:0] b_xfer_count;
  stream_sink_arbiter #(.N_PORTS(N), .DATA_W(W), .BURST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .out_data(out_data), .out_tag(out_tag), .out_stb(out_stb), .out_ack(out_ack),
    .grant(grant), .xfer_count(xfer_count)
  );
  stream_sink_arbiter #(.N_PORTS(N), .DATA_W(W), .BURST(3)) dut3 (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_stb(b_in_stb), .in_ack(b_in_ack),
    .out_data(b_out_data), .out_tag(b_out_tag), .out_stb(b_out_stb), .out_ack(1'b1),
    .grant(b_grant), .xfer_count(b_xfer_count)
  );
  int total = 0;
  int bad = 0;
  logic [31:0] src_q[N][$];
  logic [31:0] exp_q[N][$];
  int tag_log[$];
  bit m_idle = 1'b1;
  int m_ptr = 0;
  int m_cnt = 0;
  int b_cnt[2] = '{0, 0};
  int b_n = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic int pick(input logic [N-1:0] s);
    for (int k = 0; k < N; k++) if (s[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic bit pending();
    bit r;
    r = out_stb || in_ack != 0 || grant != 0;
    for (int p = 0; p < N; p++) if (src_q[p].size() != 0) r = 1'b1;
    return r;
  endfunction
  task automatic drive();
    for (int p = 0; p < N; p++) begin
      in_stb[p] = src_q[p].size() != 0;
      in_data[p*W +: W] = src_q[p].size() != 0 ? src_q[p][0] : 32'h0;
      b_in_data[p*W +: W] = p < 2 ? (32'(p) << 16) | 32'(b_cnt[p % 2]) : 32'h0;
    end
    b_in_stb = 4'b0011;
  endtask
  task automatic step();
    logic [N-1:0] p_ack, p_stb, bp_ack;
    logic [N*W-1:0] p_data;
    logic [W-1:0] p_odata, bp_odata;
    logic [1:0] p_tag, bp_tag;
    logic p_ostb, p_oack, p_rst, bp_ostb, bp_rst;
    bit idle_nxt;
    int w, et;
    p_ack = in_ack; p_stb = in_stb; p_data = in_data; p_odata = out_data; p_tag = out_tag;
    p_ostb = out_stb; p_oack = out_ack; p_rst = rst_n;
    bp_ack = b_in_ack; bp_odata = b_out_data; bp_tag = b_out_tag; bp_ostb = b_out_stb; bp_rst = b_rst_n;
    @(posedge clk);
    #1;
    if (!p_rst) begin
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_stb", out_stb, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_grant", grant, 0);
      chk("rst_xfer", xfer_count, 0);
      m_idle = 1'b1; m_ptr = 0; m_cnt = 0;
      for (int p = 0; p < N; p++) exp_q[p].delete();
    end else begin
      idle_nxt = m_idle;
      for (int p = 0; p < N; p++)
        if (p_ack[p] && p_stb[p]) begin
          exp_q[p].push_back(p_data[p*W +: W]);
          void'(src_q[p].pop_front());
        end else if (p_ack[p]) idle_nxt = 1'b1;
      if (p_ostb && p_oack) begin
        chk("out_data", {32'h0, p_odata},
            exp_q[p_tag].size() != 0 ? {32'h0, exp_q[p_tag][0]} : 64'hBAD0_0000_0000_0000);
        if (exp_q[p_tag].size() != 0) void'(exp_q[p_tag].pop_front());
        m_cnt++;
        tag_log.push_back(int'(p_tag));
        m_ptr = (int'(p_tag) + 1) % N;
        idle_nxt = 1'b1;
      end
      if (p_ostb && !p_oack) begin
        chk("hold_stb", out_stb, 1);
        chk("hold_data", out_data, p_odata);
        chk("hold_tag", out_tag, p_tag);
        chk("hold_ack", in_ack, 0);
      end
      if (m_idle) begin
        if (p_stb != 0) begin
          w = pick(p_stb);
          chk("rr_ack", in_ack, 64'(1) << w);
          chk("rr_grant", grant, 64'(1) << w);
          idle_nxt = 1'b0;
        end else begin
          chk("idle_ack", in_ack, 0);
          chk("idle_grant", grant, 0);
        end
      end
      m_idle = idle_nxt;
      chk("xfer_count", xfer_count, m_cnt);
      chk("ack_onehot0", $onehot0(in_ack), 1);
    end
    if (bp_rst) begin
      for (int p = 0; p < 2; p++) if (bp_ack[p]) b_cnt[p]++;
      if (bp_ostb && b_n < 12) begin
        et = (b_n / 3) % 2;
        chk("burst_tag", bp_tag, et);
        chk("burst_data", bp_odata, (et << 16) | ((b_n / 6) * 3 + b_n % 3));
        b_n++;
      end
    end
    drive();
  endtask
  initial begin
    logic [W-1:0] d;
    logic [1:0] t;
    logic [31:0] c0;
    rst_n = 1'b0; b_rst_n = 1'b0; out_ack = 1'b1;
    drive();
    step(); step();
    rst_n = 1'b1; b_rst_n = 1'b1;
    step();
    src_q[2].push_back(32'h0000_1234);
    drive();
    step();
    chk("single_ack", in_ack, 4'b0100);
    step();
    chk("single_stb", out_stb, 1);
    chk("single_data", out_data, 32'h1234);
    chk("single_tag", out_tag, 2);
    step();
    chk("single_xfer", xfer_count, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tag_log.delete();
    for (int p = 0; p < N; p++) for (int i = 0; i < 8; i++) src_q[p].push_back($urandom);
    drive();
    for (int i = 0; i < 100 && tag_log.size() < 8; i++) step();
    for (int i = 0; i < 8; i++) chk("rr_order", i < tag_log.size() ? tag_log[i] : -1, i % 4);
    for (int i = 0; i < 200 && pending(); i++) step();
    out_ack = 1'b0;
    src_q[1].push_back(32'hCAFE_F00D);
    drive();
    for (int i = 0; i < 10 && !out_stb; i++) step();
    chk("bp_stb_rise", out_stb, 1);
    d = out_data; t = out_tag; c0 = xfer_count;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stb", out_stb, 1);
      chk("bp_data", out_data, d);
      chk("bp_tag", out_tag, t);
      chk("bp_in_ack", in_ack, 0);
    end
    out_ack = 1'b1;
    step();
    chk("bp_release_stb", out_stb, 0);
    chk("bp_release_cnt", xfer_count, c0 + 1);
    step();
    chk("bp_one_xfer", xfer_count, c0 + 1);
    for (int i = 0; i < 400; i++) begin
      out_ack = $urandom_range(0, 9) < 7;
      for (int p = 0; p < N; p++)
        if (src_q[p].size() < 3 && $urandom_range(0, 3) == 0) src_q[p].push_back($urandom);
      drive();
      step();
    end
    out_ack = 1'b1;
    for (int i = 0; i < 200 && pending(); i++) step();
    out_ack = 1'b0;
    src_q[3].push_back(32'h5A5A_0003);
    drive();
    for (int i = 0; i < 10 && !out_stb; i++) step();
    chk("rst_send_stb", out_stb, 1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_xfer", xfer_count, 0);
    chk("rst_mid_stb", out_stb, 0);
    rst_n = 1'b1; out_ack = 1'b1;
    src_q[1].push_back(32'h1111_0001);
    src_q[3].push_back(32'h3333_0003);
    drive();
    step();
    chk("post_rst_grant", in_ack, 4'b0010);
    for (int i = 0; i < 50 && pending(); i++) step();
    src_q[1].push_back(32'hDEAD_0001);
    drive();
    step();
    chk("drop_ack", in_ack, 4'b0010);
    void'(src_q[1].pop_front());
    drive();
    step();
    chk("drop_grant", grant, 0);
    chk("drop_in_ack", in_ack, 0);
    chk("drop_out_stb", out_stb, 0);
    src_q[1].push_back(32'hBEEF_0001);
    src_q[2].push_back(32'hBEEF_0002);
    drive();
    step();
    chk("drop_regrant", in_ack, 4'b0010);
    for (int i = 0; i < 50 && pending(); i++) step();
    chk("drained", pending(), 0);
    chk("burst_done", b_n, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
